// File: rtl/digout_pkg.sv
// Shared types for the digital-output prog bus scheduler: prog register
// addresses, the queued command format and the strobe-sequencing states.
package digout_pkg;

  localparam logic [3:0] ADDR_TRIG_CFG   = 4'd0;
  localparam logic [3:0] ADDR_NUM_PULSES = 4'd1;
  localparam logic [3:0] ADDR_START      = 4'd4;
  localparam logic [3:0] ADDR_END        = 4'd7;
  localparam logic [3:0] ADDR_REPEAT     = 4'd8;
  localparam logic [3:0] ADDR_EVENT_END  = 4'd13;

  typedef struct packed {
    logic [4:0]  mod_id;
    logic [3:0]  channel;
    logic [3:0]  address;
    logic [31:0] word;
  } prog_cmd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_GAP} prog_state_t;

  function automatic logic addr_legal(input logic [3:0] a);
    return (a == ADDR_TRIG_CFG) || (a == ADDR_NUM_PULSES) || (a == ADDR_START) ||
           (a == ADDR_END) || (a == ADDR_REPEAT) || (a == ADDR_EVENT_END);
  endfunction

endpackage

// File: rtl/digout_prog_scheduler_prog_cmd_fifo.sv
// First-word-fall-through command queue; head entry is visible on o_dout
// whenever o_empty is low. i_flush discards all entries on the next edge.
module prog_cmd_fifo
  import digout_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     dataclk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  prog_cmd_t                i_din,
  input  logic                     i_pop,
  output prog_cmd_t                o_dout,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  prog_cmd_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [LW-1:0]   r_level;

  always_ff @(posedge dataclk) begin
    if (i_push) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge dataclk) begin
    if (reset || i_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop)  r_rp <= r_rp + 1'b1;
      r_level <= r_level + LW'(i_push) - LW'(i_pop);
    end
  end

  assign o_dout  = r_mem[r_rp];
  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_level = r_level;

endmodule

// File: rtl/digout_prog_scheduler.sv
// Replays queued host writes onto the shared prog bus with setup/pulse/gap timing.
// Define DIGOUT_PROG_ALIGN_EN to launch only when main_state == ALIGN_STATE.
module digout_prog_scheduler
  import digout_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int ALIGN_STATE  = 99
) (
  input  logic                         dataclk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [4:0]                   cmd_module,
  input  logic [3:0]                   cmd_channel,
  input  logic [3:0]                   cmd_address,
  input  logic [31:0]                  cmd_word,
  input  logic                         flush,
  input  logic                         hold,
  input  logic [31:0]                  main_state,
  output logic [4:0]                   prog_module,
  output logic [3:0]                   prog_channel,
  output logic [3:0]                   prog_address,
  output logic [31:0]                  prog_word,
  output logic                         prog_trig,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         bad_addr,
  output logic [15:0]                  issued_count
);
  prog_cmd_t   w_head;
  logic        w_empty, w_full, w_push, w_pop, w_window;
  prog_state_t r_state;
  logic [15:0] r_cnt;
  prog_cmd_t   r_cmd;
  logic        r_trig, r_bad;
  logic [15:0] r_issued;

  assign cmd_ready = !w_full && !flush;
  assign w_push    = cmd_valid && cmd_ready;

`ifdef DIGOUT_PROG_ALIGN_EN
  assign w_window = (main_state == 32'(ALIGN_STATE));
`else
  logic w_unused;
  assign w_unused = ^main_state;
  assign w_window = 1'b1;
`endif

  // Head is consumed in IDLE whether legal (launched) or not (dropped).
  assign w_pop = (r_state == ST_IDLE) && !w_empty && !hold && !flush && w_window;

  prog_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .dataclk (dataclk),
    .reset   (reset),
    .i_flush (flush),
    .i_push  (w_push),
    .i_din   ({cmd_module, cmd_channel, cmd_address, cmd_word}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (fifo_level)
  );

  always_ff @(posedge dataclk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_cmd    <= '0;
      r_trig   <= 1'b0;
      r_bad    <= 1'b0;
      r_issued <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_pop) begin
          if (addr_legal(w_head.address)) begin
            r_cmd   <= w_head;
            r_state <= ST_SETUP;
            r_cnt   <= 16'(SETUP_CYCLES - 1);
          end else begin
            r_bad <= 1'b1;
          end
        end
        ST_SETUP: if (r_cnt == '0) begin
          r_state  <= ST_PULSE;
          r_trig   <= 1'b1;
          r_cnt    <= 16'(PULSE_CYCLES - 1);
          r_issued <= r_issued + 16'd1;
        end else r_cnt <= r_cnt - 16'd1;
        ST_PULSE: if (r_cnt == '0) begin
          r_state <= ST_GAP;
          r_trig  <= 1'b0;
          r_cnt   <= 16'(GAP_CYCLES - 1);
        end else r_cnt <= r_cnt - 16'd1;
        ST_GAP: if (r_cnt == '0) r_state <= ST_IDLE;
                else r_cnt <= r_cnt - 16'd1;
        default: r_state <= ST_IDLE;
      endcase
      // Flush clears the sticky flags even if a strobe is being counted this edge.
      if (flush) begin
        r_bad    <= 1'b0;
        r_issued <= '0;
      end
    end
  end

  assign prog_module  = r_cmd.mod_id;
  assign prog_channel = r_cmd.channel;
  assign prog_address = r_cmd.address;
  assign prog_word    = r_cmd.word;
  assign prog_trig    = r_trig;
  assign bad_addr     = r_bad;
  assign issued_count = r_issued;
  assign busy         = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_digout_prog_scheduler.sv
// Directed bench for digout_prog_scheduler: a timeline model of launches/strobes
// is compared every cycle, plus literal latency/order/flush/reset expectations.
module tb_digout_prog_scheduler;
  import digout_pkg::*;

  localparam int S = 2, P = 2, G = 2, D = 16;
`ifdef DIGOUT_PROG_ALIGN_EN
  localparam int SPC = 20;
`else
  localparam int SPC = 1 + S + P + G;
`endif

  logic        dataclk = 1'b0, reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [4:0]  cmd_module = '0;
  logic [3:0]  cmd_channel = '0, cmd_address = '0;
  logic [31:0] cmd_word = '0, main_state = 32'd99;
  logic        flush = 1'b0, hold = 1'b0;
  logic [4:0]  prog_module;
  logic [3:0]  prog_channel, prog_address;
  logic [31:0] prog_word;
  logic        prog_trig, busy, bad_addr;
  logic [4:0]  fifo_level;
  logic [15:0] issued_count;

  digout_prog_scheduler dut (
    .dataclk(dataclk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_module(cmd_module), .cmd_channel(cmd_channel), .cmd_address(cmd_address),
    .cmd_word(cmd_word), .flush(flush), .hold(hold), .main_state(main_state),
    .prog_module(prog_module), .prog_channel(prog_channel), .prog_address(prog_address),
    .prog_word(prog_word), .prog_trig(prog_trig), .busy(busy), .fifo_level(fifo_level),
    .bad_addr(bad_addr), .issued_count(issued_count)
  );

  always #5 dataclk = ~dataclk;

  always @(negedge dataclk)
    main_state = (main_state >= 32'd118 || main_state < 32'd99) ? 32'd99 : main_state + 32'd1;

  int nvec = 0, nfail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a launch at edge L drives fields from L, raises the strobe at L+S
  // for P edges, and frees the bus for the next launch at L+S+P+G+1.
  int        cyc = 0, mL = 0, last_push = 0;
  bit        mvalid = 0, mact = 0;
  prog_cmd_t mq[$];
  prog_cmd_t mf;
  logic      mbad;
  logic [15:0] mcnt;
  int        ms_hist[int];

  function automatic bit legal(input logic [3:0] a);
    return a == 0 || a == 1 || a == 4 || a == 7 || a == 8 || a == 13;
  endfunction

  always @(posedge dataclk) begin
    prog_cmd_t h;
    bit idle_ok, rdy, win;
    ms_hist[cyc] = int'(main_state);
`ifdef DIGOUT_PROG_ALIGN_EN
    win = (main_state == 32'd99);
`else
    win = 1'b1;
`endif
    if (reset) begin
      mq.delete(); mf = '0; mact = 0; mbad = 0; mcnt = 0; mvalid = 1;
    end else begin
      idle_ok = !mact || (cyc - mL >= S + P + G + 1);
      rdy = (mq.size() < D) && !flush;
      if (mact && cyc - mL == S) mcnt++;
      if (idle_ok && mq.size() > 0 && !hold && !flush && win) begin
        h = mq.pop_front();
        if (legal(h.address)) begin mf = h; mL = cyc; mact = 1; end
        else mbad = 1;
      end
      if (flush) begin mq.delete(); mbad = 0; mcnt = 0; end
      if (cmd_valid && rdy) mq.push_back({cmd_module, cmd_channel, cmd_address, cmd_word});
    end
    cyc++;
  end

  int          rises[$];
  logic [31:0] rise_w[$];
  logic        prev_trig = 1'b0;

  always @(posedge dataclk) begin
    int k;
    #1;
    if (mvalid) begin
      k = cyc - 1 - mL;
      check("trig",     prog_trig,    mact && k >= S && k < S + P);
      check("module",   prog_module,  mf.mod_id);
      check("channel",  prog_channel, mf.channel);
      check("address",  prog_address, mf.address);
      check("word",     prog_word,    mf.word);
      check("ready",    cmd_ready,    (mq.size() < D) && !flush);
      check("busy",     busy,         (mact && k < S + P + G) || mq.size() > 0);
      check("level",    fifo_level,   mq.size());
      check("bad_addr", bad_addr,     mbad);
      check("issued",   issued_count, mcnt);
      if (prog_trig === 1'b1 && prev_trig === 1'b0) begin
        rises.push_back(cyc - 1);
        rise_w.push_back(prog_word);
      end
      prev_trig = prog_trig;
    end
  end

  task automatic send(input logic [4:0] m, input logic [3:0] ch, input logic [3:0] a,
                      input logic [31:0] w);
    bit done = 0;
    @(negedge dataclk);
    cmd_valid = 1; cmd_module = m; cmd_channel = ch; cmd_address = a; cmd_word = w;
    for (int i = 0; i < 400 && !done; i++) begin
      #1 done = cmd_ready;
      @(negedge dataclk);
    end
    cmd_valid = 0;
    last_push = cyc - 1;
    check("send_accepted", done, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(posedge dataclk); #2 ok = !busy;
    end
    check("idle_reached", ok, 1);
  endtask

  task automatic wait_trig();
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge dataclk); #2 ok = prog_trig;
    end
    check("trig_reached", ok, 1);
  endtask

  task automatic pulse_flush();
    @(negedge dataclk); flush = 1;
    @(negedge dataclk); flush = 0;
  endtask

  initial begin
    logic [3:0] addrs [6];
    addrs = '{4'd0, 4'd1, 4'd4, 4'd7, 4'd8, 4'd13};
    repeat (3) @(negedge dataclk);
    reset = 0;
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_trig", prog_trig, 0);
    check("rst_count", issued_count, 0);

    // Single command latency
    rises.delete(); rise_w.delete();
    send(5'd2, 4'd5, 4'd4, 32'h0000_1234);
    wait_idle();
    check("t1_strobes", rises.size(), 1);
    check("t1_word", prog_word, 32'h0000_1234);
    check("t1_fields", {prog_module, prog_channel, prog_address}, {5'd2, 4'd5, 4'd4});
    check("t1_count", issued_count, 1);
`ifdef DIGOUT_PROG_ALIGN_EN
    if (rises.size() > 0) check("t1_align", ms_hist[rises[0] - S], 99);
`else
    if (rises.size() > 0) check("t1_latency", rises[0] - last_push, 1 + S);
`endif

    // Fill under hold, overflow attempt, then release
    rises.delete(); rise_w.delete();
    @(negedge dataclk); hold = 1;
    for (int i = 0; i < 16; i++)
      send(5'(i), 4'(15 - i), addrs[i % 6], 32'hA000_0000 + 32'(i));
    @(negedge dataclk);
    cmd_valid = 1; cmd_word = 32'hDEAD_BEEF; cmd_address = 4'd0;
    #1;
    check("t2_ready_full", cmd_ready, 0);
    check("t2_level_full", fifo_level, 16);
    @(negedge dataclk); cmd_valid = 0; hold = 0;
    wait_idle();
    check("t2_strobes", rises.size(), 16);
    for (int i = 1; i < 16 && i < rises.size(); i++) begin
      check("t2_spacing", rises[i] - rises[i-1], SPC);
      check("t2_order", rise_w[i], 32'hA000_0000 + 32'(i));
    end
`ifdef DIGOUT_PROG_ALIGN_EN
    foreach (rises[i]) check("t2_align", ms_hist[rises[i] - S], 99);
`endif
    check("t2_count", issued_count, 17);

    // Illegal address between two legal ones
    pulse_flush();
    rises.delete(); rise_w.delete();
    send(5'd1, 4'd1, 4'd0, 32'h1111_0000);
    send(5'd1, 4'd2, 4'd3, 32'h2222_0000);
    send(5'd1, 4'd3, 4'd13, 32'h3333_0000);
    wait_idle();
    check("t3_strobes", rises.size(), 2);
    check("t3_bad", bad_addr, 1);
    check("t3_count", issued_count, 2);
    if (rises.size() == 2) check("t3_second", rise_w[1], 32'h3333_0000);

    // Flush during the first strobe with three more queued
    rises.delete(); rise_w.delete();
    @(negedge dataclk); hold = 1;
    for (int i = 0; i < 4; i++) send(5'd3, 4'd0, 4'd8, 32'hF000_0000 + 32'(i));
    @(negedge dataclk); hold = 0;
    wait_trig();
    pulse_flush();
    wait_idle();
    check("t4_strobes", rises.size(), 1);
    check("t4_count", issued_count, 0);
    check("t4_level", fifo_level, 0);
    check("t4_bad", bad_addr, 0);

    // Reset in the middle of a strobe
    send(5'd7, 4'd9, 4'd1, 32'h5555_AAAA);
    send(5'd7, 4'd9, 4'd7, 32'h6666_BBBB);
    wait_trig();
    @(negedge dataclk); reset = 1;
    @(posedge dataclk); #2;
    check("t5_trig", prog_trig, 0);
    check("t5_word", prog_word, 0);
    check("t5_ready", cmd_ready, 1);
    check("t5_level", fifo_level, 0);
    check("t5_busy", busy, 0);
    @(negedge dataclk); reset = 0;
    repeat (3) @(negedge dataclk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
